// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: state encodings, grant
// encoding and the default cache-line length.
package mem_arbiter_pkg;

  localparam int LINE_WORDS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_IC_READ  = 2'd1,
    ARB_DC_READ  = 2'd2,
    ARB_DC_WRITE = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } grant_e;

  function automatic logic is_dc_state(arb_state_e s);
    return (s == ARB_DC_READ) || (s == ARB_DC_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-requester round-robin picker: on a tie the requester that did not win
// last time is chosen; a lone requester always wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic   req_ic,
  input  logic   req_dc,
  input  grant_e last_grant,
  output logic   pick_ic,
  output logic   pick_dc
);

  logic tie;

  always_comb begin
    tie     = req_ic & req_dc;
    pick_ic = 1'b0;
    pick_dc = 1'b0;
    if (tie) begin
      pick_ic = (last_grant == GNT_DC);
      pick_dc = (last_grant == GNT_IC);
    end else begin
      pick_ic = req_ic;
      pick_dc = req_dc;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache refills, dcache refills and dcache writebacks onto the
// single main-memory port as word beats, one whole line per grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic [31:0] ic_rdata,
  output logic        ic_rvalid,
  output logic        ic_done,
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic        dc_wnext,
  output logic [31:0] dc_rdata,
  output logic        dc_rvalid,
  output logic        dc_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        ic_grant,
  output logic        dc_grant,
  output logic        icache_stall,
  output logic        dcache_stall,
  output logic [1:0]  dbg_state
);

  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = BEAT_W + 2;
  localparam int BASE_W = 32 - OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  // Handshake: a requester raises req and holds it (with addr/we) until its
  // done pulse; each memory beat completes in a cycle where mem_req and
  // mem_ready are both 1, and the owner's rvalid/wnext mirrors that cycle.

  arb_state_e          state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BASE_W-1:0]   base_q, base_d;
  grant_e              last_grant_q, last_grant_d;

  logic pick_ic, pick_dc;
  logic busy, last_beat;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0]};

  rr_pick2 u_pick (
    .req_ic     (ic_req),
    .req_dc     (dc_req),
    .last_grant (last_grant_q),
    .pick_ic    (pick_ic),
    .pick_dc    (pick_dc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      beat_q       <= '0;
      base_q       <= '0;
      last_grant_q <= GNT_IC;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant decisions are taken only in IDLE; the dcache direction is folded
  // into the state so later changes of dc_we cannot affect the transfer.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    base_d       = base_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_ic) begin
          state_d      = ARB_IC_READ;
          base_d       = ic_addr[31:OFF_W];
          beat_d       = '0;
          last_grant_d = GNT_IC;
        end else if (pick_dc) begin
          state_d      = dc_we ? ARB_DC_WRITE : ARB_DC_READ;
          base_d       = dc_addr[31:OFF_W];
          beat_d       = '0;
          last_grant_d = GNT_DC;
        end
      end
      default: begin
        if (mem_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ARB_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != ARB_IDLE);
    last_beat = busy & mem_ready & (beat_q == LAST_BEAT);

    mem_req   = busy;
    mem_addr  = busy ? {base_q, beat_q, 2'b00} : 32'h0;
    mem_we    = (state_q == ARB_DC_WRITE);
    mem_wdata = mem_we ? dc_wdata : 32'h0;

    ic_grant  = (state_q == ARB_IC_READ);
    dc_grant  = is_dc_state(state_q);

    ic_rvalid = ic_grant & mem_ready;
    ic_rdata  = ic_rvalid ? mem_rdata : 32'h0;
    ic_done   = ic_grant & last_beat;

    dc_rvalid = (state_q == ARB_DC_READ) & mem_ready;
    dc_rdata  = dc_rvalid ? mem_rdata : 32'h0;
    dc_wnext  = mem_we & mem_ready;
    dc_done   = dc_grant & last_beat;

    icache_stall = ic_req & ~ic_done;
    dcache_stall = dc_req & ~dc_done;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: line-level behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int LW = 4;
  localparam logic [31:0] LINE_MASK = ~32'(LW * 4 - 1);

  logic        clock, reset;
  logic        ic_req, dc_req, dc_we, mem_ready;
  logic [31:0] ic_addr, dc_addr, dc_wdata, mem_rdata;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
  logic        ic_rvalid, ic_done, dc_wnext, dc_rvalid, dc_done;
  logic        mem_req, mem_we, ic_grant, dc_grant, icache_stall, dcache_stall;
  logic [1:0]  dbg_state;

  mem_arbiter #(.LINE_WORDS(LW)) dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
    .ic_rvalid(ic_rvalid), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_wnext(dc_wnext), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
    .dc_done(dc_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ic_grant(ic_grant), .dc_grant(dc_grant),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // model: 0 none, 1 icache read, 2 dcache read, 3 dcache write
  int          m_owner = 0;
  int          m_cnt = 0;
  logic [31:0] m_line = 32'h0;
  logic        m_last_dc = 1'b0;
  logic        m_ic_done_now = 1'b0;
  logic        m_dc_done_now = 1'b0;
  logic        m_wnext_now = 1'b0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];
  int          log_gnt[$];
  logic        prev_ic_g = 1'b0;
  logic        prev_dc_g = 1'b0;

  // scoreboard: every cycle, compare all outputs with the model
  always @(negedge clock) begin
    logic [138:0] exp_v, act_v;
    logic         e_ic, e_dr, e_dw, e_busy, e_last;
    logic         e_icd, e_dcd;
    logic [31:0]  e_addr;
    if (!reset) begin
      m_owner = 0; m_cnt = 0; m_line = 32'h0; m_last_dc = 1'b0;
    end
    e_ic   = (m_owner == 1);
    e_dr   = (m_owner == 2);
    e_dw   = (m_owner == 3);
    e_busy = (m_owner != 0);
    e_last = e_busy && mem_ready && (m_cnt == LW - 1);
    e_addr = e_busy ? (m_line + 32'(4 * m_cnt)) : 32'h0;
    e_icd  = e_ic & e_last;
    e_dcd  = (e_dr | e_dw) & e_last;
    exp_v = {e_ic, e_dr | e_dw, e_busy, e_dw, e_addr,
             (e_dw ? dc_wdata : 32'h0),
             e_ic & mem_ready, ((e_ic & mem_ready) ? mem_rdata : 32'h0), e_icd,
             e_dr & mem_ready, ((e_dr & mem_ready) ? mem_rdata : 32'h0), e_dcd,
             e_dw & mem_ready, ic_req & ~e_icd, dc_req & ~e_dcd};
    act_v = {ic_grant, dc_grant, mem_req, mem_we, mem_addr, mem_wdata,
             ic_rvalid, ic_rdata, ic_done, dc_rvalid, dc_rdata, dc_done,
             dc_wnext, icache_stall, dcache_stall};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got %h exp %h", $time, act_v, exp_v);
    end
    m_ic_done_now = e_icd;
    m_dc_done_now = e_dcd;
    m_wnext_now   = e_dw & mem_ready;

    if (mem_req && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
      log_we.push_back(mem_we);
    end
    if (ic_grant && !prev_ic_g) log_gnt.push_back(1);
    if (dc_grant && !prev_dc_g) log_gnt.push_back(2);
    prev_ic_g = ic_grant;
    prev_dc_g = dc_grant;

    if (reset) begin
      if (m_owner == 0) begin
        if (ic_req && (!dc_req || m_last_dc)) begin
          m_owner = 1; m_line = ic_addr & LINE_MASK; m_cnt = 0; m_last_dc = 1'b0;
        end else if (dc_req) begin
          m_owner = dc_we ? 3 : 2; m_line = dc_addr & LINE_MASK; m_cnt = 0;
          m_last_dc = 1'b1;
        end
      end else if (mem_ready) begin
        m_cnt++;
        if (m_cnt == LW) begin
          m_owner = 0; m_cnt = 0;
        end
      end
    end
  end

  // driver tasks
  int cyc = 0;
  int rearm_ic = 0;
  int rearm_dc = 0;

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (m_ic_done_now) begin
      ic_req = 1'b0;
      if (rearm_ic > 0) begin ic_req = 1'b1; rearm_ic--; end
    end
    if (m_dc_done_now) begin
      dc_req = 1'b0;
      if (rearm_dc > 0) begin dc_req = 1'b1; rearm_dc--; end
    end
    if (m_wnext_now) dc_wdata = dc_wdata + 32'h1;
    mem_rdata = 32'hD000_0000 + 32'(cyc);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while ((ic_req || dc_req) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (ic_req || dc_req) begin
      errors++;
      $display("FAIL wait_idle_timeout got %0d cycles exp <%0d", n, limit);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int s, n;
    logic [5:0]  pat;
    logic [31:0] pat_addr[6];

    reset = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = 32'h0; dc_addr = 32'h0; dc_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ready = 1'b0;
    tick();
    tick();
    chk("reset_mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_grants", {30'h0, ic_grant, dc_grant}, 32'h0);
    chk("reset_done", {30'h0, ic_done, dc_done}, 32'h0);
    reset = 1'b1;

    // icache line read at 0x1014 with mem_ready held high
    tick();
    mem_ready = 1'b1;
    ic_addr = 32'h0000_1014;
    ic_req = 1'b1;
    s = log_addr.size();
    wait_idle(20, n);
    chk("ic_turnaround", 32'(n), 32'd5);
    chk("ic_beats", 32'(log_addr.size() - s), 32'd4);
    for (int i = 0; i < 4; i++)
      if (s + i < log_addr.size())
        chk("ic_addr_beat", log_addr[s + i], 32'h1010 + 32'(4 * i));

    // simultaneous requests after reset alternate, dcache first
    do_reset();
    ic_addr = 32'h100; dc_addr = 32'h200; dc_we = 1'b0;
    rearm_ic = 1; rearm_dc = 1;
    s = log_gnt.size();
    ic_req = 1'b1; dc_req = 1'b1;
    wait_idle(60, n);
    chk("tie_grants", 32'(log_gnt.size() - s), 32'd4);
    for (int i = 0; i < 4; i++)
      if (s + i < log_gnt.size())
        chk("tie_order", 32'(log_gnt[s + i]), (i % 2 == 0) ? 32'd2 : 32'd1);

    // dcache writeback 0xA0..0xA3 at 0x2000
    tick();
    dc_we = 1'b1; dc_addr = 32'h2000; dc_wdata = 32'hA0;
    dc_req = 1'b1;
    s = log_addr.size();
    wait_idle(20, n);
    chk("wb_beats", 32'(log_addr.size() - s), 32'd4);
    for (int i = 0; i < 4; i++)
      if (s + i < log_addr.size()) begin
        chk("wb_addr", log_addr[s + i], 32'h2000 + 32'(4 * i));
        chk("wb_data", log_data[s + i], 32'hA0 + 32'(i));
        chk("wb_we", {31'h0, log_we[s + i]}, 32'h1);
      end

    // icache read with mem_ready pattern 1,0,0,1,1,1
    tick();
    pat = 6'b111001;
    pat_addr[0] = 32'h5000; pat_addr[1] = 32'h5004; pat_addr[2] = 32'h5004;
    pat_addr[3] = 32'h5004; pat_addr[4] = 32'h5008; pat_addr[5] = 32'h500C;
    dc_we = 1'b0; ic_addr = 32'h5000; ic_req = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      mem_ready = pat[i];
      #2;
      chk("stall_rvalid", {31'h0, ic_rvalid}, {31'h0, pat[i]});
      chk("stall_addr", mem_addr, pat_addr[i]);
      chk("stall_done", {31'h0, ic_done}, (i == 5) ? 32'h1 : 32'h0);
    end
    mem_ready = 1'b1;
    wait_idle(10, n);

    // async reset on beat 2 of a dcache read, then a fresh request
    tick();
    dc_we = 1'b0; dc_addr = 32'h6000; dc_req = 1'b1;
    tick(); tick(); tick();
    #2;
    reset = 1'b0; dc_req = 1'b0;
    #1;
    chk("async_mem_req", {31'h0, mem_req}, 32'h0);
    chk("async_dc_grant", {31'h0, dc_grant}, 32'h0);
    chk("async_mem_addr", mem_addr, 32'h0);
    chk("async_dc_rvalid", {31'h0, dc_rvalid}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    dc_addr = 32'h7000; dc_req = 1'b1;
    tick();
    #2;
    chk("restart_addr", mem_addr, 32'h7000);
    chk("restart_grant", {31'h0, dc_grant}, 32'h1);
    wait_idle(20, n);

    // address and direction changes after grant are ignored
    tick();
    dc_we = 1'b0; dc_addr = 32'h3000; dc_req = 1'b1;
    s = log_addr.size();
    tick(); tick();
    dc_addr = 32'h4000; dc_we = 1'b1;
    wait_idle(20, n);
    chk("latch_beats", 32'(log_addr.size() - s), 32'd4);
    for (int i = 0; i < 4; i++)
      if (s + i < log_addr.size()) begin
        chk("latch_addr", log_addr[s + i], 32'h3000 + 32'(4 * i));
        chk("latch_we", {31'h0, log_we[s + i]}, 32'h0);
      end

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
